alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_arbiter_rr_arb2.sv | 27 ++
 rtl/alu_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the two-port ALU arbiter.
// Op codes, execution latencies and FSM state encoding.
package alu_pkg;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;

    localparam logic [1:0] LAT_ADD = 2'd2;
    localparam logic [1:0] LAT_DEF = 2'd1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    function automatic logic op_legal(input logic [2:0] op);
        return (op == OP_FWD) || (op == OP_ADD) ||
               (op == OP_AND) || (op == OP_OR);
    endfunction

    function automatic logic [1:0] op_lat(input logic [2:0] op);
        return (op == OP_ADD) ? LAT_ADD : LAT_DEF;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with one-hot grant.
// The pointer flips to the loser whenever a grant is taken.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_take,
    output logic [1:0] o_gnt
);

    // 1: requester 1 wins a tie
    logic r_prio;

    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11)
            o_gnt = r_prio ? 2'b10 : 2'b01;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_prio <= 1'b0;
        else if (i_take)
            r_prio <= o_gnt[0];
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters.
// Grants round-robin, waits the op latency, returns the result.
module alu_arbiter
    import alu_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ0,
    input  logic       REQ1,
    input  logic [7:0] DATA1_0,
    input  logic [7:0] DATA2_0,
    input  logic [7:0] DATA1_1,
    input  logic [7:0] DATA2_1,
    input  logic [2:0] SELECT_0,
    input  logic [2:0] SELECT_1,
    output logic       GNT0,
    output logic       GNT1,
    output logic       DONE0,
    output logic       DONE1,
    output logic       ERR,
    output logic [7:0] RESULT,
    output logic [7:0] ALU_DATA1,
    output logic [7:0] ALU_DATA2,
    output logic [2:0] ALU_SELECT,
    input  logic [7:0] ALU_RESULT
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_cnt;
    logic       r_owner;

    logic [1:0] w_req;
    logic [1:0] w_gnt;
    logic       w_take;
    logic       w_finish;
    logic [7:0] w_d1;
    logic [7:0] w_d2;
    logic [2:0] w_sel;

    assign w_req = {REQ1, REQ0};

    rr_arb2 u_arb (
        .i_clk  (CLK),
        .i_rst  (RESET),
        .i_req  (w_req),
        .i_take (w_take),
        .o_gnt  (w_gnt)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take)
                r_cnt <= op_lat(w_sel);
            else if (r_state == ST_EXEC && r_cnt != 2'd0)
                r_cnt <= r_cnt - 2'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (|w_req) w_state_nxt = ST_EXEC;
            ST_EXEC: if (r_cnt == 2'd1) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_take   = (r_state == ST_IDLE) && (|w_req);
        w_finish = (r_state == ST_EXEC) && (r_cnt == 2'd1);
        w_d1     = w_gnt[1] ? DATA1_1  : DATA1_0;
        w_d2     = w_gnt[1] ? DATA2_1  : DATA2_0;
        w_sel    = w_gnt[1] ? SELECT_1 : SELECT_0;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            GNT0       <= 1'b0;
            GNT1       <= 1'b0;
            DONE0      <= 1'b0;
            DONE1      <= 1'b0;
            ERR        <= 1'b0;
            RESULT     <= 8'h00;
            ALU_DATA1  <= 8'h00;
            ALU_DATA2  <= 8'h00;
            ALU_SELECT <= OP_FWD;
            r_owner    <= 1'b0;
        end else begin
            GNT0  <= w_take & w_gnt[0];
            GNT1  <= w_take & w_gnt[1];
            DONE0 <= w_finish & ~r_owner;
            DONE1 <= w_finish & r_owner;
            ERR   <= w_finish & ~op_legal(ALU_SELECT);
            if (w_take) begin
                ALU_DATA1  <= w_d1;
                ALU_DATA2  <= w_d2;
                ALU_SELECT <= w_sel;
                r_owner    <= w_gnt[1];
            end
            // illegal ops never expose the ALU output
            if (w_finish)
                RESULT <= op_legal(ALU_SELECT) ? ALU_RESULT : 8'h00;
        end
    end

endmodule
